upsample_2x_sched: RTL and testbench

UPSAMPLE_2X_SCHED -- requirements
Module: upsample_2x_sched

---
 rtl/upsample_pkg.sv | 22 ++
 rtl/upsample_2x_sched_ram.sv | 31 +++
 rtl/upsample_2x_sched.sv | 196 +++++++++++++++++++
 tb/tb_upsample_2x_sched.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/upsample_pkg.sv
// Shared types and sizing helpers for the 2x nearest-neighbour upsampler.
package upsample_pkg;

  typedef enum logic [1:0] {IDLE, FILL, EMIT0, EMIT1} state_t;

  typedef struct packed {
    logic valid;
    logic sop;
    logic eop;
    logic sof;
    logic eof;
  } tag_t;

  function automatic int line_len(input int string_len, input int channel_num);
    return string_len * channel_num;
  endfunction

  function automatic int cnt_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/upsample_2x_sched_ram.sv
// Simple dual-port line RAM: one write port, one read port with registered q.
module upsample_2x_sched_ram #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 10,
  parameter string RAM_STYLE  = "M10K"
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (RAM_STYLE == "MLAB") begin : g_mlab
    (* ramstyle = "MLAB" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      q <= mem[raddr];
    end
  end else begin : g_m10k
    (* ramstyle = "M10K" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/upsample_2x_sched.sv
// 2x nearest-neighbour line upsampler: buffers one line, then replays it
// twice with every pixel's channel group repeated.
module upsample_2x_sched
  import upsample_pkg::*;
#(
  parameter int    DATA_WIDTH  = 8,
  parameter int    STRING_LEN  = 224,
  parameter int    CHANNEL_NUM = 3,
  parameter string RAM_STYLE   = "M10K"
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         valid_i,
  input  logic                         sop_i,
  input  logic                         eop_i,
  input  logic                         sof_i,
  input  logic                         eof_i,
  output logic                         ready_o,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         data_valid_o,
  output logic                         sop_o,
  output logic                         eop_o,
  output logic                         sof_o,
  output logic                         eof_o,
  output logic                         err_o
);

  localparam int LINE_LEN   = line_len(STRING_LEN, CHANNEL_NUM);
  localparam int ADDR_WIDTH = cnt_width(LINE_LEN);
  localparam int PIX_WIDTH  = cnt_width(STRING_LEN);
  localparam int CHAN_WIDTH = cnt_width(CHANNEL_NUM);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LINE_LEN - 1);
  localparam logic [PIX_WIDTH-1:0]  LAST_PIX  = PIX_WIDTH'(STRING_LEN - 1);
  localparam logic [CHAN_WIDTH-1:0] LAST_CHAN = CHAN_WIDTH'(CHANNEL_NUM - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [PIX_WIDTH-1:0]    pix_q, pix_d;
  logic [CHAN_WIDTH-1:0]   chan_q, chan_d;
  logic                    rep_q, rep_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic                    sof_q, sof_d, eof_q, eof_d, err_q, err_d;

  logic                    accept, we, first, last;
  logic [ADDR_WIDTH-1:0]   waddr, rd_addr_q;
  logic [DATA_WIDTH-1:0]   ram_q;
  tag_t                    issue_tag, s1_q, s2_q, out_q;

  assign ready_o = reset_n && ((state_q == IDLE) || (state_q == FILL));
  assign accept  = valid_i && ready_o;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      pix_q     <= '0;
      chan_q    <= '0;
      rep_q     <= 1'b0;
      base_q    <= '0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      pix_q     <= pix_d;
      chan_q    <= chan_d;
      rep_q     <= rep_d;
      base_q    <= base_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    pix_d     = pix_q;
    chan_d    = chan_q;
    rep_d     = rep_q;
    base_d    = base_q;
    sof_d     = sof_q;
    eof_d     = eof_q;
    err_d     = err_q;
    we        = 1'b0;
    waddr     = wr_addr_q;
    first     = 1'b0;
    last      = 1'b0;
    issue_tag = '0;
    unique case (state_q)
      IDLE: begin
        if (accept && sop_i) begin
          we        = 1'b1;
          waddr     = '0;
          wr_addr_d = ADDR_WIDTH'(1);
          sof_d     = sof_i;
          eof_d     = eof_i;
          state_d   = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          we = 1'b1;
          // A sop at wr_addr 0 is the normal start of the next line.
          if (sop_i && (wr_addr_q != '0)) begin
            waddr     = '0;
            wr_addr_d = ADDR_WIDTH'(1);
            err_d     = 1'b1;
            sof_d     = sof_i;
            eof_d     = eof_i;
          end else begin
            if (wr_addr_q == '0) begin
              sof_d = sof_i;
              eof_d = eof_i;
            end else begin
              eof_d = eof_q | eof_i;
            end
            if (eop_i != (wr_addr_q == LAST_ADDR)) err_d = 1'b1;
            if (wr_addr_q == LAST_ADDR) begin
              wr_addr_d = '0;
              state_d   = EMIT0;
            end else begin
              wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
            end
          end
        end
      end
      EMIT0, EMIT1: begin
        first = (pix_q == '0) && (chan_q == '0) && !rep_q;
        last  = (pix_q == LAST_PIX) && (chan_q == LAST_CHAN) && rep_q;
        issue_tag.valid = 1'b1;
        issue_tag.sop   = first;
        issue_tag.eop   = last;
        issue_tag.sof   = first && (state_q == EMIT0) && sof_q;
        issue_tag.eof   = last && (state_q == EMIT1) && eof_q;
        if (chan_q == LAST_CHAN) begin
          chan_d = '0;
          rep_d  = !rep_q;
          if (rep_q) begin
            if (pix_q == LAST_PIX) begin
              pix_d   = '0;
              base_d  = '0;
              state_d = (state_q == EMIT0) ? EMIT1 : FILL;
            end else begin
              pix_d  = pix_q + PIX_WIDTH'(1);
              base_d = base_q + ADDR_WIDTH'(CHANNEL_NUM);
            end
          end
        end else begin
          chan_d = chan_q + CHAN_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read pipeline: address register, RAM q register, output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      out_q     <= '0;
      data_o    <= '0;
    end else begin
      rd_addr_q <= base_q + ADDR_WIDTH'(chan_q);
      s1_q      <= issue_tag;
      s2_q      <= s1_q;
      out_q     <= s2_q;
      data_o    <= s2_q.valid ? ram_q : '0;
    end
  end

  upsample_2x_sched_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .RAM_STYLE (RAM_STYLE)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(data_i),
    .raddr(rd_addr_q),
    .q    (ram_q)
  );

  assign data_valid_o = out_q.valid;
  assign sop_o        = out_q.sop;
  assign eop_o        = out_q.eop;
  assign sof_o        = out_q.sof;
  assign eof_o        = out_q.eof;
  assign err_o        = err_q;

endmodule

// File: tb/tb_upsample_2x_sched.sv
// Directed bench for upsample_2x_sched with STRING_LEN=4, CHANNEL_NUM=3.
module tb_upsample_2x_sched;

  localparam int L = 12;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic signed [7:0] data_i = '0;
  logic              valid_i = 1'b0, sop_i = 1'b0, eop_i = 1'b0, sof_i = 1'b0, eof_i = 1'b0;
  logic              ready_o;
  logic signed [7:0] data_o;
  logic              data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o;

  int   n_cmp = 0;
  int   n_err = 0;
  logic err_exp = 1'b0;

  // Hand-computed replay order of one output pass (24 words).
  logic [7:0] pat [24] = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd3, 8'd4, 8'd5,
                           8'd6, 8'd7, 8'd8, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd9, 8'd10, 8'd11};

  always #5 clk = ~clk;

  upsample_2x_sched #(
    .DATA_WIDTH (8),
    .STRING_LEN (4),
    .CHANNEL_NUM(3),
    .RAM_STYLE  ("M10K")
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .sop_i       (sop_i),
    .eop_i       (eop_i),
    .sof_i       (sof_i),
    .eof_i       (eof_i),
    .ready_o     (ready_o),
    .data_o      (data_o),
    .data_valid_o(data_valid_o),
    .sop_o       (sop_o),
    .eop_o       (eop_o),
    .sof_o       (sof_o),
    .eof_o       (eof_o),
    .err_o       (err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_word(input logic [7:0] d, input logic sop, input logic eop,
                            input logic sof, input logic eof);
    int unsigned guard = 0;
    valid_i = 1'b1; data_i = d; sop_i = sop; eop_i = eop; sof_i = sof; eof_i = eof;
    while (ready_o !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
  endtask

  task automatic send_line(input int base, input logic sof, input logic eof,
                           input int bad_eop, input int unsigned max_gap);
    for (int i = 0; i < L; i++) begin
      if (max_gap > 0 && i > 0)
        repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
      drive_word(8'(base + i), i == 0, (i == L - 1) || (i == bad_eop),
                 sof && (i == 0), eof && (i == L - 1));
      if (i == bad_eop) err_exp = 1'b1;
      check($sformatf("err_w%0d", i), 32'(err_o), 32'(err_exp));
    end
  endtask

  // Called right after the last word's accepting edge T; sample n is after edge T+n.
  task automatic collect(input string name, input int base, input logic sof, input logic eof);
    logic [31:0] obs, exp;
    int k, j;
    for (int n = 0; n <= 50; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      obs = 32'({ready_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, 8'(data_o)});
      if (n >= 3) begin
        k = n - 3;
        j = k % 24;
        exp = 32'({n >= 48, 1'b1, j == 0, j == 23, sof && (k == 0), eof && (k == 47),
                   8'(base + int'(pat[j]))});
      end else begin
        exp = 32'd0;
      end
      check($sformatf("%s_n%0d", name, n), obs, exp);
    end
  endtask

  initial begin
    logic seen_dv;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", 32'({ready_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o, 8'(data_o)}), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rst_ready", 32'(ready_o), 32'd1);
    @(posedge clk); #1;

    // Words without sop in IDLE are dropped
    for (int i = 0; i < 5; i++) drive_word(8'(8'hE0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    send_line(0, 1'b0, 1'b0, -1, 0);
    collect("idle_drop", 0, 1'b0, 1'b0);

    // Plain line from FILL
    send_line(0, 1'b0, 1'b0, -1, 0);
    collect("basic", 0, 1'b0, 1'b0);

    // Gapped input
    send_line(0, 1'b0, 1'b0, -1, 3);
    collect("gaps", 0, 1'b0, 1'b0);

    // Two-line frame
    send_line(32'h20, 1'b1, 1'b0, -1, 0);
    collect("frame1", 32'h20, 1'b1, 1'b0);
    send_line(32'h40, 1'b0, 1'b1, -1, 1);
    collect("frame2", 32'h40, 1'b0, 1'b1);

    // Early eop on word 7
    send_line(32'h80, 1'b0, 1'b0, 7, 0);
    collect("err_line", 32'h80, 1'b0, 1'b0);
    check("err_sticky", 32'(err_o), 32'd1);

    // Reset during output word 10
    send_line(32'h50, 1'b0, 1'b0, -1, 0);
    repeat (13) @(posedge clk);
    #1;
    check("pre_rst_word10", 32'({data_valid_o, 8'(data_o)}), 32'({1'b1, 8'h54}));
    reset_n = 1'b0;
    #1;
    check("mid_rst_outs", 32'({ready_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o, 8'(data_o)}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_hold", 32'({ready_o, data_valid_o, err_o, 8'(data_o)}), 32'd0);
    reset_n = 1'b1;
    err_exp = 1'b0;
    #1;
    check("post_rst_ready", 32'(ready_o), 32'd1);
    seen_dv = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (data_valid_o !== 1'b0) seen_dv = 1'b1;
    end
    check("post_rst_no_output", 32'(seen_dv), 32'd0);
    for (int i = 0; i < 5; i++) drive_word(8'(8'hF0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    send_line(0, 1'b0, 1'b0, -1, 0);
    collect("post_rst", 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
